// File: rtl/reg_dump_if.sv
// Output stream of the register dump engine: one {address, data} word per
// handshake, with a marker on the final word of the dump.
interface reg_dump_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_last
  );
endinterface

// File: rtl/reg_dump.sv
// Sequential read-out engine for the register file. A start pulse walks an
// inclusive, wrapping address range on the read port and streams each
// captured word as {address, data} over a valid/ready handshake.
module reg_dump #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  reg_dump_if.master        sif,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;
  logic              accept_s;

  // A word leaves the engine only on a full handshake.
  assign accept_s = out_valid_q & sif.out_ready;

  // Next-state and output decode; every register holds unless a rule moves it.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          last_d    = last_addr;
          rd_addr_d = first_addr;
          state_d   = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        // First capture: read data is already settled for the latched address.
        out_data_d  = rd_data;
        out_addr_d  = rd_addr_q;
        out_last_d  = (rd_addr_q == last_q);
        out_valid_d = 1'b1;
        rd_addr_d   = rd_addr_q + ADDR_W'(1);
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (accept_s && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else if (accept_s) begin
          // Capture the next word in the same edge the current one leaves.
          out_data_d  = rd_data;
          out_addr_d  = rd_addr_q;
          out_last_d  = (rd_addr_q == last_q);
          out_valid_d = 1'b1;
          rd_addr_d   = rd_addr_q + ADDR_W'(1);
          state_d     = S_SEND;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; clear abandons any dump in progress.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      last_q      <= '0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  assign rd_addr       = rd_addr_q;
  assign sif.out_valid = out_valid_q;
  assign sif.out_data  = out_data_q;
  assign sif.out_addr  = out_addr_q;
  assign sif.out_last  = out_last_q;
  assign done          = done_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_dump.sv
// Self-checking bench for reg_dump: a behavioural register file plus a list
// of expected {addr, data} beats derived from the range rule and the
// capture-time consistency rule.
module tb_reg_dump;

  logic        clk;
  logic        clear;
  logic        start;
  logic [3:0]  first_addr;
  logic [3:0]  last_addr;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;

  reg_dump_if #(.DATA_W(16), .ADDR_W(4)) sif ();

  reg_dump #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .sif        (sif),
    .busy       (busy),
    .done       (done)
  );

  // Register file model: combinational read port.
  logic [15:0] regs [16];
  assign rd_data = regs[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0]  exp_addr [$];
  logic [15:0] exp_data [$];
  int          rdy_pat  [$];
  int          wr_beat  [$];
  int          wr_reg   [$];
  logic [15:0] wr_val   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload();
    for (int k = 0; k < 16; k++) regs[k] = 16'h1000 + 16'(k);
  endtask

  // One dump: rmode 0 = ready always, 1 = rdy_pat then 1, 2 = random ready.
  // bs_cycle injects a start pulse while busy; abort_beat returns early.
  task automatic dump_run(input logic [3:0] f, input logic [3:0] l, input int rmode,
                          input int bs_cycle, input int abort_beat);
    logic [3:0] d;
    logic [3:0] a;
    int n, idx, cyc;
    logic r;
    d = l - f;
    n = int'(d) + 1;
    exp_addr.delete();
    exp_data.delete();
    for (int i = 0; i < n; i++) begin
      a = f + 4'(i);
      exp_addr.push_back(a);
      exp_data.push_back(regs[a]);
    end
    start = 1'b1; first_addr = f; last_addr = l; sif.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; first_addr = 4'($urandom); last_addr = 4'($urandom);
    chk("load_busy", busy, 1);
    chk("load_valid", sif.out_valid, 0);
    chk("load_rdaddr", rd_addr, f);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 400 && idx != abort_beat) begin
      @(negedge clk);
      cyc++;
      start = (cyc == bs_cycle);
      if (start) begin first_addr = 4'd8; last_addr = 4'd9; end
      chk("beat_valid", sif.out_valid, 1);
      chk("beat_addr", sif.out_addr, exp_addr[idx]);
      chk("beat_data", sif.out_data, exp_data[idx]);
      chk("beat_last", sif.out_last, (idx == n - 1) ? 1 : 0);
      chk("beat_busy", busy, 1);
      chk("beat_done", done, 0);
      // Writes land before the next edge: only words not yet captured see them.
      for (int w = 0; w < wr_beat.size(); w++) begin
        if (wr_beat[w] == idx) begin
          regs[wr_reg[w]] = wr_val[w];
          for (int j = idx + 1; j < n; j++)
            if (int'(exp_addr[j]) == wr_reg[w]) exp_data[j] = wr_val[w];
          wr_beat[w] = -1;
        end
      end
      case (rmode)
        0: r = 1'b1;
        1: r = (rdy_pat.size() > 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      sif.out_ready = r;
      if (r) idx++;
    end
    wr_beat.delete(); wr_reg.delete(); wr_val.delete();
    if (abort_beat < 0 || idx != abort_beat) begin
      chk("beat_count", idx, n);
      @(negedge clk);
      start = 1'b0; sif.out_ready = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_valid", sif.out_valid, 0);
      chk("done_last", sif.out_last, 0);
      chk("done_busy", busy, 0);
    end
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", sif.out_valid, 0);
  endtask

  initial begin
    logic [3:0] f, l, dd;
    int n;
    clear = 1'b0; start = 1'b0; first_addr = 4'd0; last_addr = 4'd0;
    sif.out_ready = 1'b0;
    preload();
    repeat (3) @(negedge clk);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_data", sif.out_data, 0);
    chk("rst_addr", sif.out_addr, 0);
    chk("rst_last", sif.out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdaddr", rd_addr, 0);
    clear = 1'b1;
    idle_check();

    // Full dump with continuous ready.
    dump_run(4'd0, 4'd15, 0, -1, -1);
    idle_check();

    // Backpressure.
    rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
    dump_run(4'd3, 4'd6, 1, -1, -1);
    idle_check();

    // Wrap, then single-word dump started in the done cycle.
    dump_run(4'd14, 4'd1, 0, -1, -1);
    dump_run(4'd5, 4'd5, 0, -1, -1);
    idle_check();

    // Start while busy is ignored; start in done cycle launches a new dump.
    dump_run(4'd0, 4'd15, 0, 3, -1);
    dump_run(4'd2, 4'd4, 2, -1, -1);
    idle_check();

    // Reset mid-dump.
    dump_run(4'd0, 4'd15, 0, -1, 4);
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    chk("arst_valid", sif.out_valid, 0);
    chk("arst_data", sif.out_data, 0);
    chk("arst_addr", sif.out_addr, 0);
    chk("arst_last", sif.out_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rdaddr", rd_addr, 0);
    sif.out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_done", done, 0);
    end
    clear = 1'b1;
    idle_check();
    dump_run(4'd0, 4'd15, 0, -1, -1);
    idle_check();

    // Concurrent writes: reg 10 not yet captured, reg 1 already captured.
    wr_beat = '{2, 5}; wr_reg = '{10, 1}; wr_val = '{16'hBEEF, 16'h0000};
    dump_run(4'd0, 4'd15, 0, -1, -1);
    chk("cw_reg1_now", regs[1], 16'h0000);
    idle_check();

    // Randomized dumps with random contents, ranges, ready and writes.
    repeat (8) begin
      for (int k = 0; k < 16; k++) regs[k] = 16'($urandom);
      f = 4'($urandom); l = 4'($urandom);
      dd = l - f; n = int'(dd) + 1;
      repeat (2) begin
        wr_beat.push_back(int'($urandom_range(0, n - 1)));
        wr_reg.push_back(int'($urandom_range(0, 15)));
        wr_val.push_back(16'($urandom));
      end
      dump_run(f, l, 2, int'($urandom_range(1, 6)), -1);
      if ($urandom_range(0, 1) == 0) idle_check();
    end
    idle_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
